// File: rtl/pll_ctrl_seq.sv
// PLL power-up / lock-supervision sequencer running on the PLL reference clock.
// Optional lock-loss event counter is enabled by defining PLL_CTRL_LOSS_CNT_EN.
module pll_ctrl_seq #(
   parameter int RST_CYCLES   = 100,
   parameter int LOCK_TIMEOUT = 50000,
   parameter int LOCK_STABLE  = 1024,
   parameter int EN_GAP       = 16,
   parameter int MAX_RETRY    = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pll_lock,
   input  logic       restart,
   output logic       pll_reset,
   output logic [2:0] pll_enclk,
   output logic       sys_rst_n,
   output logic       ready,
   output logic       fault,
   output logic [1:0] retry_cnt,
   output logic [7:0] loss_cnt
);

   // state      | meaning
   // ST_RESET   | pll_reset held high for RST_CYCLES
   // ST_WAIT    | waiting for LOCK_STABLE consecutive lock cycles, bounded by LOCK_TIMEOUT
   // ST_ENABLE  | staggering enclk0..2 EN_GAP apart
   // ST_RUN     | locked, outputs enabled, system reset released
   // ST_FAULT   | retries exhausted, parked until restart or rst_n

   localparam int RST_W = $clog2(RST_CYCLES) + 1;
   localparam int TMO_W = $clog2(LOCK_TIMEOUT) + 1;
   localparam int STB_W = $clog2(LOCK_STABLE) + 1;
   localparam int GAP_W = $clog2(EN_GAP) + 1;

   localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);
   localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(EN_GAP - 1);

   typedef enum logic [2:0] {
      ST_RESET  = 3'd0,
      ST_WAIT   = 3'd1,
      ST_ENABLE = 3'd2,
      ST_RUN    = 3'd3,
      ST_FAULT  = 3'd4
   } state_t;

   state_t           state_q,     state_d;
   logic [1:0]       sync_q,      sync_d;
   logic [RST_W-1:0] rst_cnt_q,   rst_cnt_d;
   logic [TMO_W-1:0] tmo_cnt_q,   tmo_cnt_d;
   logic [STB_W-1:0] stb_cnt_q,   stb_cnt_d;
   logic [GAP_W-1:0] gap_cnt_q,   gap_cnt_d;
   logic             pll_reset_q, pll_reset_d;
   logic [2:0]       enclk_q,     enclk_d;
   logic             sys_rst_n_q, sys_rst_n_d;
   logic             ready_q,     ready_d;
   logic             fault_q,     fault_d;
   logic [1:0]       retry_q,     retry_d;
   logic [1:0]       retry_inc;
   logic             lock_s;
`ifdef PLL_CTRL_LOSS_CNT_EN
   logic [7:0]       loss_q,      loss_d;
`endif

   assign lock_s    = sync_q[1];
   assign retry_inc = (retry_q == 2'b11) ? retry_q : retry_q + 2'd1;

   always_comb begin
      state_d     = state_q;
      sync_d      = {sync_q[0], pll_lock};
      rst_cnt_d   = '0;
      tmo_cnt_d   = '0;
      stb_cnt_d   = '0;
      gap_cnt_d   = '0;
      pll_reset_d = pll_reset_q;
      enclk_d     = enclk_q;
      sys_rst_n_d = sys_rst_n_q;
      ready_d     = ready_q;
      fault_d     = fault_q;
      retry_d     = retry_q;
`ifdef PLL_CTRL_LOSS_CNT_EN
      loss_d      = loss_q;
`endif
      if (restart) begin
         state_d     = ST_RESET;
         sync_d      = '0;
         pll_reset_d = 1'b1;
         enclk_d     = 3'b000;
         sys_rst_n_d = 1'b0;
         ready_d     = 1'b0;
         fault_d     = 1'b0;
         retry_d     = 2'd0;
      end else begin
         case (state_q)
            ST_RESET: begin
               // lock from a PLL held in reset is meaningless; restart qualification from scratch
               sync_d = '0;
               if (rst_cnt_q == RST_LAST) begin
                  state_d     = ST_WAIT;
                  pll_reset_d = 1'b0;
               end else begin
                  rst_cnt_d = rst_cnt_q + 1'b1;
               end
            end
            ST_WAIT: begin
               if (lock_s && (stb_cnt_q == STB_LAST)) begin
                  state_d = ST_ENABLE;
                  enclk_d = 3'b001;
               end else if (tmo_cnt_q == TMO_LAST) begin
                  retry_d     = retry_inc;
                  pll_reset_d = 1'b1;
                  if (int'(retry_inc) == MAX_RETRY) begin
                     state_d = ST_FAULT;
                     fault_d = 1'b1;
                  end else begin
                     state_d = ST_RESET;
                  end
               end else begin
                  tmo_cnt_d = tmo_cnt_q + 1'b1;
                  stb_cnt_d = lock_s ? stb_cnt_q + 1'b1 : '0;
               end
            end
            ST_ENABLE: begin
               if (!lock_s) begin
                  state_d     = ST_RESET;
                  enclk_d     = 3'b000;
                  pll_reset_d = 1'b1;
               end else if (gap_cnt_q == GAP_LAST) begin
                  if (!enclk_q[1]) begin
                     enclk_d = 3'b011;
                  end else if (!enclk_q[2]) begin
                     enclk_d = 3'b111;
                  end else begin
                     state_d     = ST_RUN;
                     ready_d     = 1'b1;
                     sys_rst_n_d = 1'b1;
                     retry_d     = 2'd0;
                  end
               end else begin
                  gap_cnt_d = gap_cnt_q + 1'b1;
               end
            end
            ST_RUN: begin
               if (!lock_s) begin
                  state_d     = ST_RESET;
                  ready_d     = 1'b0;
                  sys_rst_n_d = 1'b0;
                  enclk_d     = 3'b000;
                  pll_reset_d = 1'b1;
`ifdef PLL_CTRL_LOSS_CNT_EN
                  if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
`endif
               end
            end
            ST_FAULT: begin
               sync_d = '0;
            end
            default: begin
               state_d     = ST_RESET;
               sync_d      = '0;
               pll_reset_d = 1'b1;
               enclk_d     = 3'b000;
               sys_rst_n_d = 1'b0;
               ready_d     = 1'b0;
               fault_d     = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_RESET;
         sync_q      <= '0;
         rst_cnt_q   <= '0;
         tmo_cnt_q   <= '0;
         stb_cnt_q   <= '0;
         gap_cnt_q   <= '0;
         pll_reset_q <= 1'b1;
         enclk_q     <= 3'b000;
         sys_rst_n_q <= 1'b0;
         ready_q     <= 1'b0;
         fault_q     <= 1'b0;
         retry_q     <= 2'd0;
`ifdef PLL_CTRL_LOSS_CNT_EN
         loss_q      <= 8'd0;
`endif
      end else begin
         state_q     <= state_d;
         sync_q      <= sync_d;
         rst_cnt_q   <= rst_cnt_d;
         tmo_cnt_q   <= tmo_cnt_d;
         stb_cnt_q   <= stb_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         pll_reset_q <= pll_reset_d;
         enclk_q     <= enclk_d;
         sys_rst_n_q <= sys_rst_n_d;
         ready_q     <= ready_d;
         fault_q     <= fault_d;
         retry_q     <= retry_d;
`ifdef PLL_CTRL_LOSS_CNT_EN
         loss_q      <= loss_d;
`endif
      end
   end

   assign pll_reset = pll_reset_q;
   assign pll_enclk = enclk_q;
   assign sys_rst_n = sys_rst_n_q;
   assign ready     = ready_q;
   assign fault     = fault_q;
   assign retry_cnt = retry_q;
`ifdef PLL_CTRL_LOSS_CNT_EN
   assign loss_cnt  = loss_q;
`else
   assign loss_cnt  = 8'd0;
`endif

endmodule

// File: tb/tb_pll_ctrl_seq.sv
// Directed bench for pll_ctrl_seq with short timing parameters.
// Edge counts below are posedges after the edge whose sample first sees an input change.
module tb_pll_ctrl_seq;

`ifdef PLL_CTRL_LOSS_CNT_EN
   localparam int LOSS_ON = 1;
`else
   localparam int LOSS_ON = 0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pll_lock;
   logic       restart;
   logic       pll_reset;
   logic [2:0] pll_enclk;
   logic       sys_rst_n;
   logic       ready;
   logic       fault;
   logic [1:0] retry_cnt;
   logic [7:0] loss_cnt;

   int n_cmp = 0;
   int n_err = 0;

   pll_ctrl_seq #(
      .RST_CYCLES  (4),
      .LOCK_TIMEOUT(64),
      .LOCK_STABLE (8),
      .EN_GAP      (2),
      .MAX_RETRY   (2)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .pll_lock (pll_lock),
      .restart  (restart),
      .pll_reset(pll_reset),
      .pll_enclk(pll_enclk),
      .sys_rst_n(sys_rst_n),
      .ready    (ready),
      .fault    (fault),
      .retry_cnt(retry_cnt),
      .loss_cnt (loss_cnt)
   );

   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " pll_reset"}, 32'(pll_reset), 32'd1);
      chk({tag, " enclk"},     32'(pll_enclk), 32'd0);
      chk({tag, " sys_rst_n"}, 32'(sys_rst_n), 32'd0);
      chk({tag, " ready"},     32'(ready),     32'd0);
      chk({tag, " fault"},     32'(fault),     32'd0);
      chk({tag, " retry"},     32'(retry_cnt), 32'd0);
      chk({tag, " loss"},      32'(loss_cnt),  32'd0);
   endtask

   initial begin
      rst_n    = 1'b0;
      pll_lock = 1'b1;
      restart  = 1'b0;
      tick(3);
      chk_reset_vals("rst");

      // 1: power-up with lock already high
      rst_n = 1'b1;
      tick(3);  chk("t1 prst@3",   32'(pll_reset), 32'd1);
      tick(1);  chk("t1 prst@4",   32'(pll_reset), 32'd0);
      tick(9);  chk("t1 en@13",    32'(pll_enclk), 32'b000);
      tick(1);  chk("t1 en@14",    32'(pll_enclk), 32'b001);
      tick(1);  chk("t1 en@15",    32'(pll_enclk), 32'b001);
      tick(1);  chk("t1 en@16",    32'(pll_enclk), 32'b011);
      tick(2);  chk("t1 en@18",    32'(pll_enclk), 32'b111);
                chk("t1 rdy@18",   32'(ready),     32'd0);
      tick(1);  chk("t1 rdy@19",   32'(ready),     32'd0);
      tick(1);  chk("t1 rdy@20",   32'(ready),     32'd1);
                chk("t1 srst@20",  32'(sys_rst_n), 32'd1);
                chk("t1 prst@20",  32'(pll_reset), 32'd0);

      // 4: 3-cycle lock drop in RUN
      pll_lock = 1'b0;
      tick(2);  chk("t4 rdy@2",    32'(ready),     32'd1);
      tick(1);  chk("t4 rdy@3",    32'(ready),     32'd0);
                chk("t4 srst@3",   32'(sys_rst_n), 32'd0);
                chk("t4 en@3",     32'(pll_enclk), 32'b000);
                chk("t4 prst@3",   32'(pll_reset), 32'd1);
                chk("t4 loss",     32'(loss_cnt),  32'(LOSS_ON));
      pll_lock = 1'b1;
      tick(3);  chk("t4 prst@R3",  32'(pll_reset), 32'd1);
      tick(1);  chk("t4 prst@R4",  32'(pll_reset), 32'd0);
      tick(10); chk("t4 en@R14",   32'(pll_enclk), 32'b001);
      tick(6);  chk("t4 rdy@R20",  32'(ready),     32'd1);
                chk("t4 loss2",    32'(loss_cnt),  32'(LOSS_ON));

      // 5: restart, then lose lock during ENABLE
      restart = 1'b1;
      tick(1);  restart = 1'b0;
                chk("t5 rs prst",  32'(pll_reset), 32'd1);
                chk("t5 rs rdy",   32'(ready),     32'd0);
      tick(14); chk("t5 en@S14",   32'(pll_enclk), 32'b001);
      pll_lock = 1'b0;
      tick(2);  chk("t5 en@S16",   32'(pll_enclk), 32'b011);
      tick(1);  chk("t5 en@S17",   32'(pll_enclk), 32'b000);
                chk("t5 prst@S17", 32'(pll_reset), 32'd1);
                chk("t5 retry",    32'(retry_cnt), 32'd0);
                chk("t5 loss",     32'(loss_cnt),  32'(LOSS_ON));
      pll_lock = 1'b1;
      tick(14); chk("t6 en@mid",   32'(pll_enclk), 32'b001);

      // 6: rst_n together with restart mid-ENABLE
      rst_n   = 1'b0;
      restart = 1'b1;
      tick(1);
      chk_reset_vals("t6");

      // 2: lock toggling during WAIT_LOCK
      rst_n    = 1'b1;
      restart  = 1'b0;
      pll_lock = 1'b0;
      tick(4);  chk("t2 prst@4",   32'(pll_reset), 32'd0);
      for (int i = 0; i < 4; i++) begin
         pll_lock = ~pll_lock;
         tick(5);
      end
      chk("t2 en toggled", 32'(pll_enclk), 32'b000);
      pll_lock = 1'b1;
      tick(9);  chk("t2 en@F9",    32'(pll_enclk), 32'b000);
      tick(1);  chk("t2 en@F10",   32'(pll_enclk), 32'b001);

      // 3: lock never arrives -> two timeouts then FAULT
      rst_n    = 1'b0;
      pll_lock = 1'b0;
      tick(1);
      rst_n = 1'b1;
      tick(67); chk("t3 retry@67", 32'(retry_cnt), 32'd0);
                chk("t3 prst@67",  32'(pll_reset), 32'd0);
      tick(1);  chk("t3 retry@68", 32'(retry_cnt), 32'd1);
                chk("t3 prst@68",  32'(pll_reset), 32'd1);
                chk("t3 flt@68",   32'(fault),     32'd0);
      tick(4);  chk("t3 prst@72",  32'(pll_reset), 32'd0);
      tick(63); chk("t3 flt@135",  32'(fault),     32'd0);
      tick(1);  chk("t3 flt@136",  32'(fault),     32'd1);
                chk("t3 retry2",   32'(retry_cnt), 32'd2);
                chk("t3 prst flt", 32'(pll_reset), 32'd1);
                chk("t3 en flt",   32'(pll_enclk), 32'b000);
      tick(5);  chk("t3 flt hold", 32'(fault),     32'd1);
      restart = 1'b1;
      tick(1);  restart = 1'b0;
                chk("t3 rs flt",   32'(fault),     32'd0);
                chk("t3 rs retry", 32'(retry_cnt), 32'd0);
                chk("t3 rs prst",  32'(pll_reset), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
